// File: rtl/anim_sequencer_pkg.sv
// Shared display package: LCD geometry, pixel width and sequencer state
// encodings. Used by anim_sequencer and the spi_lcd driver.
package anim_sequencer_pkg;

  localparam int LCD_H = 162;  // rows per frame
  localparam int LCD_W = 132;  // pixels per row
  localparam int PIX_W = 16;   // RGB565 pixel width

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } anim_state_t;

endpackage

// File: rtl/anim_sequencer_frame_timer.sv
// Frame timer: counts LCD refreshes per frame and steps the frame index.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - restart at frame 0, hold count 0 (new animation loaded)
//   tick       - one LCD refresh completed while playing
//   frame_idx  - frame currently displayed
//   advance    - the next tick will move to another frame
//   wrap       - the next tick will move past the last frame
module frame_timer #(
  parameter int NUM_FRAMES   = 8,
  parameter int HOLD_REFRESH = 3,
  parameter int FRAME_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               tick,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               advance,
  output logic               wrap
);

  localparam int HOLD_W = $clog2(HOLD_REFRESH + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_REFRESH - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  logic [HOLD_W-1:0]  hold_q;
  logic [FRAME_W-1:0] frame_q;

  // Look-ahead flags so the parent can decide its next state from them
  // without a combinational path back through tick.
  assign advance   = (hold_q == HOLD_LAST);
  assign wrap      = advance && (frame_q == FRAME_LAST);
  assign frame_idx = frame_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_q  <= '0;
      frame_q <= '0;
    end else if (tick) begin
      if (advance) begin
        hold_q  <= '0;
        frame_q <= wrap ? '0 : frame_q + FRAME_W'(1);
      end else begin
        hold_q <= hold_q + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/anim_sequencer.sv
// Animation sequencer: selects which stored animation/frame the LCD shows
// and converts the driver's row request into a frame ROM row address.
// All visible changes happen only on lcd_frame_done so a refresh never
// mixes two frames.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   go              - request to advance to the next animation (pulses accumulate)
//   loop_en         - 1 loops the current animation, 0 plays it once
//   lcd_row         - row being fetched by the LCD driver
//   lcd_frame_done  - end-of-refresh pulse from the LCD driver
//   rom_addr        - registered frame ROM row address (1-cycle latency)
//   anim_id         - animation displayed
//   frame_idx       - frame displayed
//   playing         - high while in PLAY
module anim_sequencer #(
  parameter  int NUM_ANIM     = 4,
  parameter  int NUM_FRAMES   = 8,
  parameter  int HOLD_REFRESH = 3,
  parameter  int LCD_H        = anim_sequencer_pkg::LCD_H,
  parameter  int LCD_W        = anim_sequencer_pkg::LCD_W,
  localparam int ANIM_W       = $clog2(NUM_ANIM),
  localparam int FRAME_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  localparam int ADDR_W       = $clog2(NUM_ANIM * NUM_FRAMES * LCD_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              loop_en,
  input  logic [7:0]        lcd_row,
  input  logic              lcd_frame_done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ANIM_W-1:0] anim_id,
  output logic [FRAME_W-1:0] frame_idx,
  output logic              playing
);

  import anim_sequencer_pkg::*;

  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(NUM_ANIM - 1);

  anim_state_t       state_q, state_d;
  logic [ANIM_W-1:0] anim_q, anim_d;
  logic              pend_q, pend_d;
  logic [ANIM_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] addr_p1;

  logic [ANIM_W-1:0] base, go_tgt, tgt_eff;
  logic              pend_eff;
  logic              timer_clear, timer_tick;
  logic              advance, wrap;

  // Out-of-range rows saturate to the last visible row.
  function automatic logic [7:0] clamp_row(input logic [7:0] row);
    clamp_row = (32'(row) >= 32'(LCD_H)) ? 8'(LCD_H - 1) : row;
  endfunction

  function automatic logic [ADDR_W-1:0] row_addr(input logic [ANIM_W-1:0]  a,
                                                 input logic [FRAME_W-1:0] f,
                                                 input logic [7:0]         row);
    row_addr = ADDR_W'((32'(a) * 32'(NUM_FRAMES) + 32'(f)) * 32'(LCD_H)
                       + 32'(clamp_row(row)));
  endfunction

  frame_timer #(
    .NUM_FRAMES   (NUM_FRAMES),
    .HOLD_REFRESH (HOLD_REFRESH),
    .FRAME_W      (FRAME_W)
  ) u_frame_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .tick      (timer_tick),
    .frame_idx (frame_idx),
    .advance   (advance),
    .wrap      (wrap)
  );

  // A go in the same cycle as lcd_frame_done is folded into the pending
  // request first, so it takes effect at that very boundary.
  always_comb begin
    base     = pend_q ? tgt_q : anim_q;
    go_tgt   = (base == ANIM_LAST) ? '0 : base + ANIM_W'(1);
    pend_eff = pend_q | go;
    tgt_eff  = go ? go_tgt : tgt_q;
  end

  always_comb begin
    state_d     = state_q;
    anim_d      = anim_q;
    pend_d      = pend_eff;
    tgt_d       = tgt_eff;
    timer_clear = 1'b0;
    timer_tick  = 1'b0;
    if (lcd_frame_done) begin
      if (pend_eff) begin
        pend_d      = 1'b0;
        timer_clear = 1'b1;
        anim_d      = tgt_eff;
        // Cycling round to animation 0 means back to the static screen.
        state_d     = (tgt_eff == '0) ? ST_IDLE : ST_PLAY;
      end else if (state_q == ST_PLAY) begin
        timer_tick = 1'b1;
        if (wrap && !loop_en) begin
          state_d = ST_IDLE;
          anim_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      anim_q  <= '0;
      pend_q  <= 1'b0;
      tgt_q   <= '0;
      addr_p1 <= '0;
    end else begin
      state_q <= state_d;
      anim_q  <= anim_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      // stage p1: registered ROM row address
      addr_p1 <= row_addr(anim_q, frame_idx, lcd_row);
    end
  end

  assign rom_addr = addr_p1;
  assign anim_id  = anim_q;
  assign playing  = (state_q == ST_PLAY);

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with default parameters
// (4 animations, 8 frames, hold 3, 162 rows).
module tb_anim_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        loop_en;
  logic [7:0]  lcd_row;
  logic        lcd_frame_done;
  logic [12:0] rom_addr;
  logic [1:0]  anim_id;
  logic [2:0]  frame_idx;
  logic        playing;

  int tests = 0;
  int fails = 0;

  anim_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .go             (go),
    .loop_en        (loop_en),
    .lcd_row        (lcd_row),
    .lcd_frame_done (lcd_frame_done),
    .rom_addr       (rom_addr),
    .anim_id        (anim_id),
    .frame_idx      (frame_idx),
    .playing        (playing)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go = 1'b0;
    lcd_frame_done = 1'b0;
    lcd_row = 8'd0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    step();
    go = 1'b0;
    step();
  endtask

  task automatic pulse_fd();
    lcd_frame_done = 1'b1;
    step();
    lcd_frame_done = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    loop_en = 1'b0;
    do_reset();
    tests++; if (anim_id !== 2'd0) begin fails++; $display("FAIL reset_anim: got %0d want 0", anim_id); end
    tests++; if (frame_idx !== 3'd0) begin fails++; $display("FAIL reset_frame: got %0d want 0", frame_idx); end
    tests++; if (playing !== 1'b0) begin fails++; $display("FAIL reset_playing: got %0b want 0", playing); end
    tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
  endtask

  task automatic test_go_play();
    do_reset();
    loop_en = 1'b1;
    repeat (8) step();
    pulse_go();
    tests++; if (anim_id !== 2'd0 || playing !== 1'b0) begin fails++; $display("FAIL go_tearfree: anim %0d playing %0b want 0 0", anim_id, playing); end
    pulse_fd();
    tests++; if (anim_id !== 2'd1) begin fails++; $display("FAIL go_anim: got %0d want 1", anim_id); end
    tests++; if (frame_idx !== 3'd0) begin fails++; $display("FAIL go_frame0: got %0d want 0", frame_idx); end
    tests++; if (playing !== 1'b1) begin fails++; $display("FAIL go_playing: got %0b want 1", playing); end
    pulse_fd();
    pulse_fd();
    tests++; if (frame_idx !== 3'd0) begin fails++; $display("FAIL hold_frame: got %0d want 0", frame_idx); end
    pulse_fd();
    tests++; if (frame_idx !== 3'd1) begin fails++; $display("FAIL hold_advance: got %0d want 1", frame_idx); end
  endtask

  task automatic test_play_once();
    do_reset();
    loop_en = 1'b0;
    pulse_go();
    pulse_fd();
    repeat (23) pulse_fd();
    tests++; if (playing !== 1'b1 || frame_idx !== 3'd7 || anim_id !== 2'd1) begin
      fails++; $display("FAIL once_last: playing %0b frame %0d anim %0d want 1 7 1", playing, frame_idx, anim_id); end
    pulse_fd();
    tests++; if (playing !== 1'b0) begin fails++; $display("FAIL once_idle: playing %0b want 0", playing); end
    tests++; if (anim_id !== 2'd0 || frame_idx !== 3'd0) begin
      fails++; $display("FAIL once_home: anim %0d frame %0d want 0 0", anim_id, frame_idx); end
  endtask

  task automatic test_loop();
    do_reset();
    loop_en = 1'b1;
    pulse_go();
    pulse_fd();
    repeat (23) pulse_fd();
    tests++; if (frame_idx !== 3'd7) begin fails++; $display("FAIL loop_last: got %0d want 7", frame_idx); end
    pulse_fd();
    tests++; if (frame_idx !== 3'd0 || playing !== 1'b1 || anim_id !== 2'd1) begin
      fails++; $display("FAIL loop_wrap: frame %0d playing %0b anim %0d want 0 1 1", frame_idx, playing, anim_id); end
  endtask

  task automatic test_multi_go();
    pulse_go();
    repeat (3) step();
    pulse_go();
    tests++; if (anim_id !== 2'd1) begin fails++; $display("FAIL multi_hold: got %0d want 1", anim_id); end
    pulse_fd();
    tests++; if (anim_id !== 2'd3 || frame_idx !== 3'd0 || playing !== 1'b1) begin
      fails++; $display("FAIL multi_switch: anim %0d frame %0d playing %0b want 3 0 1", anim_id, frame_idx, playing); end
    pulse_go();
    pulse_fd();
    tests++; if (anim_id !== 2'd0 || playing !== 1'b0) begin
      fails++; $display("FAIL multi_wrap_idle: anim %0d playing %0b want 0 0", anim_id, playing); end
  endtask

  task automatic test_coincident();
    go = 1'b1;
    lcd_frame_done = 1'b1;
    step();
    go = 1'b0;
    lcd_frame_done = 1'b0;
    tests++; if (anim_id !== 2'd1 || playing !== 1'b1) begin
      fails++; $display("FAIL coinc_idle: anim %0d playing %0b want 1 1", anim_id, playing); end
    step();
    go = 1'b1;
    lcd_frame_done = 1'b1;
    step();
    go = 1'b0;
    lcd_frame_done = 1'b0;
    tests++; if (anim_id !== 2'd2 || frame_idx !== 3'd0) begin
      fails++; $display("FAIL coinc_play: anim %0d frame %0d want 2 0", anim_id, frame_idx); end
  endtask

  task automatic test_rom_addr();
    loop_en = 1'b1;
    step();
    repeat (15) pulse_fd();
    tests++; if (anim_id !== 2'd2 || frame_idx !== 3'd5) begin
      fails++; $display("FAIL addr_setup: anim %0d frame %0d want 2 5", anim_id, frame_idx); end
    lcd_row = 8'd10;
    tests++; if (rom_addr !== 13'd3402) begin fails++; $display("FAIL addr_latency: got %0d want 3402", rom_addr); end
    step();
    tests++; if (rom_addr !== 13'd3412) begin fails++; $display("FAIL addr_row10: got %0d want 3412", rom_addr); end
    lcd_row = 8'd200;
    step();
    tests++; if (rom_addr !== 13'd3563) begin fails++; $display("FAIL addr_clamp200: got %0d want 3563", rom_addr); end
    lcd_row = 8'd0;
    step();
    tests++; if (rom_addr !== 13'd3402) begin fails++; $display("FAIL addr_row0: got %0d want 3402", rom_addr); end
    lcd_row = 8'd162;
    step();
    tests++; if (rom_addr !== 13'd3563) begin fails++; $display("FAIL addr_clamp162: got %0d want 3563", rom_addr); end
  endtask

  task automatic test_rst_mid();
    lcd_row = 8'd10;
    step();
    go = 1'b1;
    rst = 1'b1;
    step();
    go = 1'b0;
    rst = 1'b0;
    tests++; if (anim_id !== 2'd0 || frame_idx !== 3'd0) begin
      fails++; $display("FAIL rst_mid_pos: anim %0d frame %0d want 0 0", anim_id, frame_idx); end
    tests++; if (playing !== 1'b0) begin fails++; $display("FAIL rst_mid_playing: got %0b want 0", playing); end
    tests++; if (rom_addr !== 13'd0) begin fails++; $display("FAIL rst_mid_addr: got %0d want 0", rom_addr); end
    pulse_fd();
    tests++; if (playing !== 1'b0 || anim_id !== 2'd0) begin
      fails++; $display("FAIL rst_no_pending: playing %0b anim %0d want 0 0", playing, anim_id); end
    tests++; if (rom_addr !== 13'd10) begin fails++; $display("FAIL rst_after_addr: got %0d want 10", rom_addr); end
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    loop_en = 1'b0;
    lcd_row = 8'd0;
    lcd_frame_done = 1'b0;
    test_reset();
    test_go_play();
    test_play_once();
    test_loop();
    test_multi_go();
    test_coincident();
    test_rom_addr();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
